if_neuron_array_sched: RTL
==========================

// Module: if_neuron_array_sched
// PURPOSE
// - Time-multiplexed scheduler for a population of N integrate-and-fire neurons that share one accumulate/compare datapath.
// - Round-robin arbitration between per-neuron spike requesters; membrane potentials held in an internal register array.
// - Produces a one-cycle fire pulse per neuron; sits between the spike-event sources and downstream spike consumers.
// PARAMETERS
// - N_NEURONS       4    number of virtual neurons / requesters (>=2)
// - THRESHOLD       5    potential at or above which the neuron fires
// - WEIGHT          1    potential increment per accepted spike (>=1)
// - REFRACT_CYCLES  8    refractory length in clk cycles; used only with REFRACTORY_EN
// - PW = $clog2(THRESHOLD+WEIGHT+1)   derived potential width
// PORTS
// - clk         in   1          rising-edge clock
// - reset       in   1          asynchronous, active-high reset
// - clear       in   1          synchronous clear of all potentials and the FSM
// - spike_req   in   N_NEURONS  per-neuron spike request, level, held until acked
// - spike_ack   out  N_NEURONS  one-hot, one-cycle acceptance pulse
// - fire        out  N_NEURONS  one-hot, one-cycle fire pulse
// - fire_valid  out  1          high in the same cycle as any fire bit
// - fire_id     out  $clog2(N_NEURONS)  index of firing neuron; 0 when fire_valid=0
// - busy        out  1          high while FSM in S_UPDATE
// BEHAVIOUR
// - Reset: spike_ack, fire, fire_valid, fire_id, busy = 0; all potentials 0; RR pointer 0; FSM S_IDLE. Takes effect immediately, mid-op included.
// - FSM: S_IDLE -> S_UPDATE when any spike_req bit is high; S_UPDATE -> S_IDLE unconditionally.
// - S_IDLE: grant g = first requesting index at or after pointer (wrapping); register g; pointer <= (g+1) mod N.
// - S_UPDATE: spike_ack[g]=1 for this cycle only, busy=1; p = pot[g] + WEIGHT.
// -   p >= THRESHOLD: pot[g] <= 0; fire[g], fire_valid, fire_id=g asserted the following cycle (1 cycle).
// -   else pot[g] <= p. No saturation needed: PW holds THRESHOLD+WEIGHT.
// - Requester drops spike_req on the clk edge that ends its ack cycle; a req still high in the next S_IDLE is a new spike.
// - Latency: req seen in S_IDLE cycle t -> ack in t+1 -> fire (if any) in t+2. Throughput: 1 spike per 2 cycles.
// - All N requesting continuously: grants in strict rotation 0,1,..,N-1,0,..; each neuron served once per 2N cycles.
// - No request in S_IDLE: FSM stays, pointer unchanged.
// - clear (priority over everything except reset): potentials <= 0, FSM <= S_IDLE, no ack issued for an aborted S_UPDATE, pending fire pulse suppressed; pointer kept.
// - fire pulse of neuron g and S_IDLE arbitration happen in the same cycle; fire does not stall the FSM.
// CONFIGURATION
// - Macro REFRACTORY_EN.
// - Defined: per-neuron counter rc[i] loaded with REFRACT_CYCLES on fire; decrements by 1 each cycle to 0. A spike granted while rc[g]!=0 is still acked but not integrated (pot[g] unchanged, no fire). clear also zeroes all rc.
// - Undefined: no counters synthesised, REFRACT_CYCLES ignored; every acked spike integrates.
// TESTING
// - Reset, drive spike_req[0] for 5 handshakes -> 5 acks, fire[0]/fire_valid pulse 1 cycle after 5th ack, fire_id=0; 4 handshakes only -> no fire.
// - spike_req=4'b1111 held (re-raised after each ack) -> acks 0,1,2,3,0.. every 2 cycles; after 20 acks fire pulses for 0,1,2,3 in order.
// - Pointer=2 (after granting 1), spike_req=4'b1010 -> neuron 3 acked first, then 1.
// - clear asserted in S_UPDATE for neuron 2 with pot[2]=4 -> no ack, no fire, all potentials 0; next 5 spikes on 2 fire once.
// - reset asserted asynchronously mid-S_UPDATE -> spike_ack, fire, busy drop to 0 before next clk edge; potentials 0.
// - REFRACTORY_EN, REFRACT_CYCLES=8: neuron 0 fires, 3 spikes within 8 cycles acked but ignored, then 5 more spikes -> exactly one further fire.

Source files
------------

// File: rtl/if_neuron_array_sched_if.sv
// Spike request/acknowledge and fire-output bundle for the neuron array scheduler.
// master = spike source / consumer side, slave = scheduler side.
interface if_neuron_array_sched_if #(
   parameter int N_NEURONS = 4
);
   localparam int IW = $clog2(N_NEURONS);

   logic [N_NEURONS-1:0] spike_req;
   logic [N_NEURONS-1:0] spike_ack;
   logic [N_NEURONS-1:0] fire;
   logic                 fire_valid;
   logic [IW-1:0]        fire_id;
   logic                 busy;

   modport master (
      output spike_req,
      input  spike_ack, fire, fire_valid, fire_id, busy
   );

   modport slave (
      input  spike_req,
      output spike_ack, fire, fire_valid, fire_id, busy
   );
endinterface

// File: rtl/if_neuron_array_sched.sv
// Integrate-and-fire scheduler: N neurons share one accumulate/compare path under round-robin
// arbitration. Define REFRACTORY_EN to add per-neuron refractory counters.
//
// state    | meaning
// S_IDLE   | arbitrate spike_req, latch grant, advance round-robin pointer
// S_UPDATE | ack granted neuron, integrate its potential, decide fire
module if_neuron_array_sched #(
   parameter int N_NEURONS      = 4,
   parameter int THRESHOLD      = 5,
   parameter int WEIGHT         = 1,
   parameter int REFRACT_CYCLES = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   if_neuron_array_sched_if.slave nif
);
   localparam int IW = $clog2(N_NEURONS);
   localparam int PW = $clog2(THRESHOLD + WEIGHT + 1);
   localparam logic [PW-1:0] THR_P = PW'(THRESHOLD);
   localparam logic [PW-1:0] WGT_P = PW'(WEIGHT);
   localparam logic [IW:0]   N_P   = (IW+1)'(N_NEURONS);
   localparam logic [IW:0]   ONE_P = (IW+1)'(1);

   typedef enum logic {S_IDLE, S_UPDATE} state_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        grant_q, grant_d;
   logic [PW-1:0]        pot_q [N_NEURONS];
   logic [N_NEURONS-1:0] fire_q;
   logic                 fire_valid_q;
   logic [IW-1:0]        fire_id_q;
   logic [N_NEURONS-1:0] ack;

   logic [IW:0]          scan_idx;
   logic [IW:0]          ptr_inc;
   logic                 found;
   logic                 accept;
   logic                 upd;
   logic                 integrate;
   logic                 fire_now;
   logic                 refractory;
   logic [PW-1:0]        pot_sum;

   // Round-robin: first requester at or after the pointer, wrapping at N.
   always_comb begin
      grant_d  = ptr_q;
      found    = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < N_NEURONS; k++) begin
         scan_idx = {1'b0, ptr_q} + (IW+1)'(k);
         if (scan_idx >= N_P) scan_idx = scan_idx - N_P;
         if (!found && nif.spike_req[scan_idx[IW-1:0]]) begin
            found   = 1'b1;
            grant_d = scan_idx[IW-1:0];
         end
      end
      ptr_inc = {1'b0, grant_d} + ONE_P;
      if (ptr_inc >= N_P) ptr_inc = '0;
      ptr_d = ptr_inc[IW-1:0];
   end

   always_comb begin
      state_d = state_q;
      ack     = '0;
      case (state_q)
         S_IDLE: begin
            if (|nif.spike_req) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            state_d = S_IDLE;
            if (!clear) ack[grant_q] = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (clear) state_d = S_IDLE;
   end

   assign accept    = (state_q == S_IDLE) && (|nif.spike_req) && !clear;
   assign upd       = (state_q == S_UPDATE) && !clear;
   assign pot_sum   = pot_q[grant_q] + WGT_P;
   assign integrate = upd && !refractory;
   assign fire_now  = integrate && (pot_sum >= THR_P);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q        <= '0;
         grant_q      <= '0;
         fire_q       <= '0;
         fire_valid_q <= 1'b0;
         fire_id_q    <= '0;
         for (int i = 0; i < N_NEURONS; i++) pot_q[i] <= '0;
      end else begin
         fire_q       <= '0;
         fire_valid_q <= 1'b0;
         fire_id_q    <= '0;
         if (clear) begin
            for (int i = 0; i < N_NEURONS; i++) pot_q[i] <= '0;
         end else begin
            if (accept) begin
               grant_q <= grant_d;
               ptr_q   <= ptr_d;
            end
            // PW is wide enough for THRESHOLD+WEIGHT, so the sum never wraps.
            if (integrate) pot_q[grant_q] <= fire_now ? '0 : pot_sum;
            if (fire_now) begin
               fire_q[grant_q] <= 1'b1;
               fire_valid_q    <= 1'b1;
               fire_id_q       <= grant_q;
            end
         end
      end
   end

`ifdef REFRACTORY_EN
   localparam int RCW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
   localparam logic [RCW-1:0] RC_LOAD = RCW'(REFRACT_CYCLES);

   logic [RCW-1:0] rc_q [N_NEURONS];

   // Loaded on the integrate edge that fires; counts down every cycle afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_NEURONS; i++) rc_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_NEURONS; i++) begin
            if (clear) begin
               rc_q[i] <= '0;
            end else if (fire_now && (grant_q == IW'(i))) begin
               rc_q[i] <= RC_LOAD;
            end else if (rc_q[i] != '0) begin
               rc_q[i] <= rc_q[i] - 1'b1;
            end
         end
      end
   end

   assign refractory = (rc_q[grant_q] != '0);
`else
   assign refractory = 1'b0;
`endif

   assign nif.spike_ack  = ack;
   assign nif.fire       = fire_q;
   assign nif.fire_valid = fire_valid_q;
   assign nif.fire_id    = fire_id_q;
   assign nif.busy       = (state_q == S_UPDATE);

endmodule
